// File: rtl/argmax_stage.sv
// Argmax stage: buffers one inference worth of class scores and
// tracks the running maximum, publishing the winning class.
module argmax_stage #(
  parameter int CLASS_NUM  = 43,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [31:0]           wr_addr_in,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  input  logic                  wr_en_in,
  input  logic                  work_finished_in,
  output logic [IDX_WIDTH-1:0]  class_idx,
  output logic [DATA_WIDTH-1:0] class_score,
  output logic                  class_valid,
  output logic                  busy,
  output logic                  err_oor,
  output logic                  err_short,
  input  logic [IDX_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int AW = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1;
  localparam int CW = $clog2(CLASS_NUM + 1);
  localparam logic [31:0] CN32 = 32'(CLASS_NUM);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLASS_NUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t                         state_q;
  logic [CW-1:0]                  cnt_q;
  logic signed [DATA_WIDTH-1:0]   max_q;
  logic [IDX_WIDTH-1:0]           max_idx_q;
  logic [IDX_WIDTH-1:0]           class_idx_q;
  logic [DATA_WIDTH-1:0]          class_score_q;
  logic                           class_valid_q;
  logic                           err_oor_q;
  logic                           err_short_q;
  logic [DATA_WIDTH-1:0]          rd_data_q;
  logic [DATA_WIDTH-1:0]          mem_q [CLASS_NUM];

  logic                           collect;
  logic                           addr_ok;
  logic                           wr_ok;
  logic                           wr_oor;
  logic                           take;
  logic                           full;
  logic                           short_fin;
  logic                           rd_ok;
  logic [IDX_WIDTH-1:0]           wr_idx;
  logic [AW-1:0]                  wr_slot;
  logic [AW-1:0]                  rd_slot;
  logic signed [DATA_WIDTH-1:0]   wr_score;
  logic signed [DATA_WIDTH-1:0]   max_d;
  logic [IDX_WIDTH-1:0]           max_idx_d;

  assign collect  = en && (state_q == COLLECT);
  assign addr_ok  = wr_addr_in < CN32;
  assign wr_ok    = collect && wr_en_in && addr_ok;
  assign wr_oor   = collect && wr_en_in && !addr_ok;
  assign wr_idx   = wr_addr_in[IDX_WIDTH-1:0];
  assign wr_slot  = wr_addr_in[AW-1:0];
  assign wr_score = wr_data_in;
  assign rd_ok    = 32'(rd_addr) < CN32;
  assign rd_slot  = rd_addr[AW-1:0];

  // Equal scores keep the lower index whatever the arrival order.
  always_comb begin
    take = 1'b0;
    if (wr_ok) begin
      take = (cnt_q == '0) ||
             (wr_score > max_q) ||
             ((wr_score == max_q) && (wr_idx < max_idx_q));
    end
    max_d     = take ? wr_score : max_q;
    max_idx_d = take ? wr_idx : max_idx_q;
  end

  assign full      = wr_ok && (cnt_q == CNT_LAST);
  assign short_fin = collect && !wr_ok && work_finished_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      max_q         <= '0;
      max_idx_q     <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      class_valid_q <= 1'b0;
      err_oor_q     <= 1'b0;
      err_short_q   <= 1'b0;
      rd_data_q     <= '0;
      for (int i = 0; i < CLASS_NUM; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_data_q     <= rd_ok ? mem_q[rd_slot] : '0;
      class_valid_q <= 1'b0;
      if (wr_ok) begin
        mem_q[wr_slot] <= wr_data_in;
      end
      if (!en) begin
        state_q       <= IDLE;
        cnt_q         <= '0;
        max_q         <= '0;
        max_idx_q     <= '0;
        class_idx_q   <= '0;
        class_score_q <= '0;
        err_oor_q     <= 1'b0;
        err_short_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= COLLECT;
          end
          COLLECT: begin
            if (wr_ok) begin
              cnt_q <= cnt_q + CW'(1);
            end
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            if (wr_oor) begin
              err_oor_q <= 1'b1;
            end
            if (short_fin) begin
              err_short_q <= 1'b1;
            end
            if (full || short_fin) begin
              state_q       <= DONE;
              class_idx_q   <= max_idx_d;
              class_score_q <= max_d;
              class_valid_q <= 1'b1;
            end
          end
          DONE: begin
            state_q <= DONE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign class_idx   = class_idx_q;
  assign class_score = class_score_q;
  assign class_valid = class_valid_q;
  assign busy        = (state_q == COLLECT);
  assign err_oor     = err_oor_q;
  assign err_short   = err_short_q;
  assign rd_data     = rd_data_q;

endmodule
